// File: rtl/wimax_pkg.sv
// Shared definitions for the WiMAX PRBS randomizer / derandomizer pair.
package wimax_pkg;

  localparam int LFSR_W = 15;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 15'b101_010_001_110_110;

  localparam int DEFAULT_BLOCK_LEN = 96;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Keystream bit of the 1 + x^14 + x^15 generator for a given register state.
  function automatic logic prbs_key(input logic [LFSR_W-1:0] lfsr);
    return lfsr[13] ^ lfsr[14];
  endfunction

endpackage

// File: rtl/prbs_derandomizer_if.sv
// Handshake bundle between the derandomizer and its upstream/downstream peers.
interface prbs_derandomizer_if;

  logic        seed_load;
  logic        data_in;
  logic        valid_in;
  logic        ready_out;
  logic        data_out;
  logic        valid_out;
  logic        last_out;
  logic        ready_in;
  logic [15:0] bit_count;

  // Environment side: drives the burst control, input stream and downstream ready.
  modport master (
    output seed_load, data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, last_out, bit_count
  );

  // Derandomizer side.
  modport slave (
    input  seed_load, data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, last_out, bit_count
  );

endinterface

// File: rtl/prbs_lfsr15.sv
// 15-bit Fibonacci LFSR with synchronous seed load and single-bit step.
// Shared between the transmit randomizer and the receive derandomizer.
module prbs_lfsr15
  import wimax_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic step_i,
  output logic key_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              key_s;

  assign key_s = prbs_key(lfsr_q);
  assign key_o = key_s;

  // Next register value: load wins over step, otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (step_i) begin
      lfsr_d = {lfsr_q[13:0], key_s};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register; cleared to zero so a seed load is needed before use.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= {LFSR_W{1'b0}};
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/prbs_derandomizer.sv
// Receive-side PRBS derandomizer: XORs each accepted bit with the LFSR
// keystream, restarts the keystream every BLOCK_LEN bits, and presents the
// result through a single output register stage with valid/ready handshake.
module prbs_derandomizer
  import wimax_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED,
  parameter int                BLOCK_LEN = DEFAULT_BLOCK_LEN
) (
  input  logic                clock,
  input  logic                reset,
  prbs_derandomizer_if.slave  bus
);

  localparam logic [15:0] LAST_IDX = 16'(BLOCK_LEN - 1);

  state_e      state_q;
  state_e      state_d;
  logic [15:0] bit_count_q;
  logic [15:0] bit_count_d;
  logic        data_q;
  logic        data_d;
  logic        valid_q;
  logic        valid_d;
  logic        last_q;
  logic        last_d;

  logic        ready_s;
  logic        accept_s;
  logic        xfer_s;
  logic        last_idx_s;
  logic        key_s;
  logic        lfsr_load_s;
  logic        lfsr_step_s;

  assign last_idx_s  = (bit_count_q == LAST_IDX);
  assign accept_s    = bus.valid_in && ready_s;
  assign xfer_s      = valid_q && bus.ready_in;
  // The block boundary reloads the seed; a burst start does the same.
  assign lfsr_load_s = bus.seed_load || (accept_s && last_idx_s);
  assign lfsr_step_s = accept_s && !last_idx_s;

  prbs_lfsr15 #(
    .SEED (SEED)
  ) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .load_i (lfsr_load_s),
    .step_i (lfsr_step_s),
    .key_o  (key_s)
  );

  // Input readiness: only while running, when the output slot is free or
  // draining, and never in the cycle a burst restart is requested.
  always_comb begin
    ready_s = 1'b0;
    if (state_q == RUN) begin
      ready_s = (!valid_q || bus.ready_in) && !bus.seed_load;
    end else begin
      ready_s = 1'b0;
    end
  end

  // Burst FSM: leave IDLE on the first seed load and stay running until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.seed_load) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Bit index within the block: restart on seed load, wrap at the block end.
  always_comb begin
    bit_count_d = bit_count_q;
    if (bus.seed_load) begin
      bit_count_d = 16'd0;
    end else if (accept_s) begin
      if (last_idx_s) begin
        bit_count_d = 16'd0;
      end else begin
        bit_count_d = bit_count_q + 16'd1;
      end
    end else begin
      bit_count_d = bit_count_q;
    end
  end

  // Output slot: load on acceptance (replacing any draining bit), empty on a
  // transfer with nothing new, otherwise hold for a stalled downstream.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (accept_s) begin
      data_d  = bus.data_in ^ key_s;
      valid_d = 1'b1;
      last_d  = last_idx_s;
    end else if (xfer_s) begin
      data_d  = data_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_count_q <= 16'd0;
      data_q      <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  assign bus.ready_out = ready_s;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.last_out  = last_q;
  assign bus.bit_count = bit_count_q;

endmodule
